cluster_pwr_seq_ctrl: RTL
=========================

// Module: cluster_pwr_seq_ctrl
// PURPOSE
//  Sequences cluster power-up/power-down for the SoC domain's cluster interface.
//  It drives power enable, clock enable, reset, fetch enable and boot address in a fixed order.
//  Commands come from an FC-side register block over a valid/ready handshake.
//  Sits in the SoC domain between the APB control registers and the cluster_* outputs.
// PARAMETERS
//  PWR_UP_CYCLES   16            cycles cluster_pow_o is high before the clock is enabled (>=1)
//  RST_HOLD_CYCLES 8             cycles reset stays asserted with the clock running (>=1)
//  DRAIN_TIMEOUT   1024          max cycles to wait for cluster idle on power-down (>=1)
//  BOOT_ADDR_RST   64'h1C008080  boot address after reset
//  CNT_WIDTH       11            counter width; must hold max(PWR_UP, RST_HOLD, DRAIN_TIMEOUT)
// PORTS
//  clk_i                   in   1   SoC clock
//  rst_ni                  in   1   async active-low reset
//  cmd_valid_i             in   1   command valid
//  cmd_ready_o             out  1   command accepted when valid&ready
//  cmd_on_i                in   1   1 = power up, 0 = power down
//  cmd_fetch_en_i          in   1   fetch enable to apply when RUN is reached
//  cmd_boot_addr_i         in   64  boot address, latched on power-up accept
//  cluster_busy_i          in   1   cluster busy, async; 2-flop synchronised inside
//  cluster_pow_o           out  1   cluster power enable
//  cluster_clk_en_o        out  1   enable for the cluster clock gate
//  cluster_rstn_o          out  1   cluster reset, active low
//  cluster_fetch_enable_o  out  1   core fetch enable
//  cluster_boot_addr_o     out  64  latched boot address
//  done_o                  out  1   1-cycle pulse when a command completes
//  timeout_o               out  1   1-cycle pulse when the drain wait expires
//  state_o                 out  3   current FSM state, for status register
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: pow=0, clk_en=0, rstn=0, fetch=0, boot_addr=BOOT_ADDR_RST,
//    done=0, timeout=0, state=OFF, cmd_ready=1.
//  - States: OFF=0, PWR_UP=1, RST_HOLD=2, RUN=3, DRAIN=4, RST_DN=5, CLK_GATE=6.
//  - cmd_ready_o=1 only in OFF and RUN. Commands are never queued.
//  - A redundant command is a no-op: cmd_on=0 accepted in OFF, or cmd_on=1 accepted in RUN.
//    It gives done_o=1 on the next cycle and does not change state, boot_addr or fetch.
//  - Power-up, command accepted at edge T:
//    - Boot address is latched at T.
//    - PWR_UP for cycles T+1..T+P, with pow=1.
//    - RST_HOLD for R cycles, with clk_en=1 and rstn=0.
//    - RUN: rstn=1, fetch=latched cmd_fetch_en_i, done_o pulse in the first RUN cycle.
//    - So rstn rises at cycle T+1+P+R.
//  - Power-down, accepted in RUN:
//    - DRAIN: fetch=0 in the first DRAIN cycle. Stay until the synchronised busy is 0.
//    - If DRAIN_TIMEOUT cycles elapse first, timeout_o pulses and the sequence proceeds anyway.
//    - RST_DN for R cycles with rstn=0 and clk_en=1.
//    - CLK_GATE for 1 cycle with clk_en=0.
//    - OFF: pow=0, done_o pulse in the first OFF cycle.
//  - Counter loads 0 on every state entry.
//    A state exits when the counter reaches N-1, so it lasts exactly N cycles.
//  - The counter never wraps; it saturates at all-ones.
//  - Busy is sampled after the synchroniser only. Raw cluster_busy_i is never used.
//  - Asserting rst_ni mid-sequence returns to OFF immediately, with all outputs at reset values.
//  - Glitch-free rules:
//    - pow, clk_en and rstn never change in the same cycle as each other.
//    - rstn=1 only while clk_en=1 and pow=1.
//    - clk_en=1 only while pow=1.
// TESTING (P=4, R=2, DRAIN_TIMEOUT=8)
//  1. Reset, then on cmd with boot 0x1C008080, fetch=1, accepted at cycle 10:
//     pow=1 at cycle 11, clk_en=1 at 15, rstn=1 and fetch=1 at 17, done pulse at 17, state=3.
//  2. From RUN, off cmd with busy held 0:
//     fetch=0 next cycle; DRAIN exits 2 cycles later (synchroniser); rstn=0 for 2 cycles;
//     clk_en=0 for 1 cycle; pow=0 and done pulse; state=0.
//  3. From RUN, off cmd with busy stuck 1: timeout_o pulses once after 8 DRAIN cycles,
//     then the sequence completes to OFF with done pulse.
//  4. Redundant cmd_on=1 in RUN with boot 0xDEAD0000: done pulse only;
//     boot_addr stays 0x1C008080; no state change.
//  5. cmd_valid held during PWR_UP: cmd_ready=0 and nothing is accepted.
//     The command is taken in the first RUN cycle.
//  6. rst_ni asserted in RST_HOLD: all outputs return to reset values asynchronously.
//     After release, state=OFF and cmd_ready=1.

Source files
------------

// File: rtl/cluster_pwr_seq_ctrl.sv
// Cluster power sequencer: steps the cluster interface through power, clock,
// reset and fetch enables in a fixed, glitch-free order on power-up and the
// reverse order on power-down. Every output comes straight from a flop; next
// values are computed from the next FSM state.
module cluster_pwr_seq_ctrl #(
   parameter int unsigned PWR_UP_CYCLES   = 16,
   parameter int unsigned RST_HOLD_CYCLES = 8,
   parameter int unsigned DRAIN_TIMEOUT   = 1024,
   parameter logic [63:0] BOOT_ADDR_RST   = 64'h0000_0000_1C00_8080,
   parameter int unsigned CNT_WIDTH       = 11
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_on_i,
   input  logic        cmd_fetch_en_i,
   input  logic [63:0] cmd_boot_addr_i,
   input  logic        cluster_busy_i,
   output logic        cluster_pow_o,
   output logic        cluster_clk_en_o,
   output logic        cluster_rstn_o,
   output logic        cluster_fetch_enable_o,
   output logic [63:0] cluster_boot_addr_o,
   output logic        done_o,
   output logic        timeout_o,
   output logic [2:0]  state_o
);

   localparam logic [2:0] ST_OFF      = 3'd0;
   localparam logic [2:0] ST_PWR_UP   = 3'd1;
   localparam logic [2:0] ST_RST_HOLD = 3'd2;
   localparam logic [2:0] ST_RUN      = 3'd3;
   localparam logic [2:0] ST_DRAIN    = 3'd4;
   localparam logic [2:0] ST_RST_DN   = 3'd5;
   localparam logic [2:0] ST_CLK_GATE = 3'd6;

   localparam logic [CNT_WIDTH-1:0] PWR_LAST   = CNT_WIDTH'(PWR_UP_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] RST_LAST   = CNT_WIDTH'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(DRAIN_TIMEOUT - 1);
   // DRAIN always spans at least the synchroniser depth, so a busy level
   // raised in reaction to fetch going low has time to reach busy_sync.
   localparam logic [CNT_WIDTH-1:0] DRAIN_MIN  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

   logic [2:0]           state;
   logic [2:0]           next_state;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic                 busy_meta;
   logic                 busy_sync;
   logic                 fetch_lat;
   logic                 fetch_lat_nxt;
   logic                 fetch_nxt;
   logic [63:0]          boot_nxt;
   logic                 done_nxt;
   logic                 timeout_nxt;
   logic                 accept;

   assign state_o = state;
   assign accept  = cmd_valid_i & cmd_ready_o;

   // Two-flop synchroniser for the asynchronous cluster busy flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_meta <= 1'b0;
         busy_sync <= 1'b0;
      end else begin
         busy_meta <= cluster_busy_i;
         busy_sync <= busy_meta;
      end
   end

   // Next-state, counter and pulse/datapath decode.
   always_comb begin
      next_state    = state;
      fetch_lat_nxt = fetch_lat;
      fetch_nxt     = cluster_fetch_enable_o;
      boot_nxt      = cluster_boot_addr_o;
      done_nxt      = 1'b0;
      timeout_nxt   = 1'b0;
      case (state)
         ST_OFF: begin
            if (accept) begin
               if (cmd_on_i) begin
                  next_state    = ST_PWR_UP;
                  boot_nxt      = cmd_boot_addr_i;
                  fetch_lat_nxt = cmd_fetch_en_i;
               end else begin
                  done_nxt = 1'b1;
               end
            end else begin
               next_state = ST_OFF;
            end
         end
         ST_PWR_UP: begin
            if (cnt == PWR_LAST) begin
               next_state = ST_RST_HOLD;
            end else begin
               next_state = ST_PWR_UP;
            end
         end
         ST_RST_HOLD: begin
            if (cnt == RST_LAST) begin
               next_state = ST_RUN;
               fetch_nxt  = fetch_lat;
               done_nxt   = 1'b1;
            end else begin
               next_state = ST_RST_HOLD;
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (!cmd_on_i) begin
                  next_state = ST_DRAIN;
                  fetch_nxt  = 1'b0;
               end else begin
                  done_nxt = 1'b1;
               end
            end else begin
               next_state = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!busy_sync && (cnt >= DRAIN_MIN)) begin
               next_state = ST_RST_DN;
            end else if (cnt == DRAIN_LAST) begin
               next_state  = ST_RST_DN;
               timeout_nxt = 1'b1;
            end else begin
               next_state = ST_DRAIN;
            end
         end
         ST_RST_DN: begin
            if (cnt == RST_LAST) begin
               next_state = ST_CLK_GATE;
            end else begin
               next_state = ST_RST_DN;
            end
         end
         ST_CLK_GATE: begin
            next_state = ST_OFF;
            done_nxt   = 1'b1;
         end
         default: begin
            next_state = ST_OFF;
            fetch_nxt  = 1'b0;
         end
      endcase

      if (next_state != state) begin
         cnt_nxt = '0;
      end else if (cnt != CNT_MAX) begin
         cnt_nxt = cnt + CNT_WIDTH'(1);
      end else begin
         cnt_nxt = cnt;
      end
   end

   // State, counter and registered outputs; enables follow the next state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state                  <= ST_OFF;
         cnt                    <= '0;
         fetch_lat              <= 1'b0;
         cmd_ready_o            <= 1'b1;
         cluster_pow_o          <= 1'b0;
         cluster_clk_en_o       <= 1'b0;
         cluster_rstn_o         <= 1'b0;
         cluster_fetch_enable_o <= 1'b0;
         cluster_boot_addr_o    <= BOOT_ADDR_RST;
         done_o                 <= 1'b0;
         timeout_o              <= 1'b0;
      end else begin
         state                  <= next_state;
         cnt                    <= cnt_nxt;
         fetch_lat              <= fetch_lat_nxt;
         cmd_ready_o            <= (next_state == ST_OFF) || (next_state == ST_RUN);
         cluster_pow_o          <= (next_state != ST_OFF);
         cluster_clk_en_o       <= (next_state == ST_RST_HOLD) || (next_state == ST_RUN) ||
                                   (next_state == ST_DRAIN)    || (next_state == ST_RST_DN);
         cluster_rstn_o         <= (next_state == ST_RUN) || (next_state == ST_DRAIN);
         cluster_fetch_enable_o <= fetch_nxt;
         cluster_boot_addr_o    <= boot_nxt;
         done_o                 <= done_nxt;
         timeout_o              <= timeout_nxt;
      end
   end

endmodule
